fpu_nibble_sub_seq: RTL and testbench

Multi-cycle wide subtractor controller for the FPU_COMMON library. It computes A − B − Bin on a DATA_WIDTH-bit unsigned word by time-sharing one 4-bit lookahead subtract slice, least-significant nibble first, with a registered borrow chain. It is used where area matters more than latency, such as exponent difference and index arithmetic in the FFT control path. Input and output use valid/ready handshakes.

---
 rtl/fpu_seq_pkg.sv | 5 +
 rtl/sub_nibble_cla.sv | 23 ++
 rtl/fpu_nibble_sub_seq.sv | 86 ++++++++
 tb/tb_fpu_nibble_sub_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared state encoding and slice width for sequenced FPU_COMMON units
package fpu_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
    localparam int NIBBLE_W = 4;
endpackage

// File: rtl/sub_nibble_cla.sv
// sub_nibble_cla: combinational 4-bit a - b - bin slice with lookahead borrow
module sub_nibble_cla
    import fpu_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] diff,
    output logic                bout
);
    logic [NIBBLE_W-1:0] g, p;
    logic [NIBBLE_W:0]   c;
    assign g = ~a & b;
    assign p = ~(a ^ b);
    assign c[0] = bin;
    assign c[1] = g[0] | (p[0] & bin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bin);
    assign diff = a ^ b ^ c[NIBBLE_W-1:0];
    assign bout = c[NIBBLE_W];
endmodule

// File: rtl/fpu_nibble_sub_seq.sv
// fpu_nibble_sub_seq: multi-cycle A - B - Bin using one 4-bit slice, LS nibble first
module fpu_nibble_sub_seq
    import fpu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_bin,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_diff,
    output logic                  o_borrow,
    output logic                  o_zero,
    output logic                  o_busy
);
    localparam int NIBBLES = DATA_WIDTH / NIBBLE_W;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    seq_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-1:0] a_reg, b_reg, diff_reg, diff_nxt;
    logic brw, zero_reg, s_bout, last;
    logic [NIBBLE_W-1:0] s_diff;

    sub_nibble_cla u_slice (
        .a    (a_reg[NIBBLE_W*cnt +: NIBBLE_W]),
        .b    (b_reg[NIBBLE_W*cnt +: NIBBLE_W]),
        .bin  (brw),
        .diff (s_diff),
        .bout (s_bout)
    );

    assign last = cnt == LAST;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (i_valid ? RUN : IDLE)
                  : state == RUN  ? (last ? DONE : RUN)
                  :                 (i_ready ? IDLE : DONE);
        o_ready = state == IDLE;
        o_valid = state == DONE;
        o_busy  = state != IDLE;
    end

    always_comb begin
        diff_nxt = diff_reg;
        diff_nxt[NIBBLE_W*cnt +: NIBBLE_W] = s_diff;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            brw      <= 1'b0;
            zero_reg <= 1'b0;
            cnt      <= '0;
        end else if (state == IDLE && i_valid) begin
            a_reg    <= i_a;
            b_reg    <= i_b;
            brw      <= i_bin;
            diff_reg <= '0;
            cnt      <= '0;
        end else if (state == RUN) begin
            diff_reg <= diff_nxt;
            brw      <= s_bout;
            cnt      <= last ? cnt : cnt + 1'b1;
            // zero flag sees the final nibble via diff_nxt, not the stale register
            if (last) zero_reg <= ~|diff_nxt;
        end
    end

    assign o_diff   = diff_reg;
    assign o_borrow = brw;
    assign o_zero   = zero_reg;
endmodule

// File: tb/tb_fpu_nibble_sub_seq.sv
// tb_fpu_nibble_sub_seq: directed and streamed checks of the nibble-serial subtractor
module tb_fpu_nibble_sub_seq;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0, i_bin = 1'b0;
    logic [31:0] i_a = '0, i_b = '0;
    logic        o_ready, o_valid, o_borrow, o_zero, o_busy;
    logic [31:0] o_diff;
    int errors = 0, checks = 0;

    fpu_nibble_sub_seq #(.DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_bin(i_bin), .o_valid(o_valid), .i_ready(i_ready),
        .o_diff(o_diff), .o_borrow(o_borrow), .o_zero(o_zero), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_wait(input logic [31:0] a, input logic [31:0] b, input logic bin, input string tag);
        int n;
        i_a = a; i_b = b; i_bin = bin; i_valid = 1'b1; i_ready = 1'b0;
        chk({tag, "_ready"}, 64'(o_ready), 64'd1);
        tick;
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd8);
    endtask

    task automatic check_result(input string tag, input logic [31:0] ed, input logic eb, input logic ez);
        chk({tag, "_diff"}, 64'(o_diff), 64'(ed));
        chk({tag, "_borrow"}, 64'(o_borrow), 64'(eb));
        chk({tag, "_zero"}, 64'(o_zero), 64'(ez));
    endtask

    task automatic consume(input string tag);
        i_ready = 1'b1;
        tick;
        i_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(o_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(o_ready), 64'd1);
    endtask

    logic [31:0] sa [100];
    logic [31:0] sb [100];
    logic        sc [100];
    logic [32:0] r;

    initial begin
        tick; tick;
        i_rst = 1'b0;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_diff", 64'(o_diff), 64'd0);
        chk("rst_borrow", 64'(o_borrow), 64'd0);
        chk("rst_zero", 64'(o_zero), 64'd0);

        start_wait(32'h0000_0010, 32'h0000_0001, 1'b0, "t1");
        chk("t1_busy", 64'(o_busy), 64'd1);
        check_result("t1", 32'h0000_000F, 1'b0, 1'b0);
        consume("t1");

        start_wait(32'h0000_0000, 32'h0000_0001, 1'b0, "t2");
        check_result("t2", 32'hFFFF_FFFF, 1'b1, 1'b0);
        consume("t2");

        start_wait(32'h1234_5678, 32'h1234_5678, 1'b0, "t3a");
        check_result("t3a", 32'h0000_0000, 1'b0, 1'b1);
        consume("t3a");
        start_wait(32'h1234_5678, 32'h1234_5678, 1'b1, "t3b");
        check_result("t3b", 32'hFFFF_FFFF, 1'b1, 1'b0);
        consume("t3b");

        start_wait(32'h8000_0000, 32'h0000_0001, 1'b1, "t4");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                i_a = 32'hDEAD_BEEF; i_b = 32'h0000_0123; i_bin = 1'b0; i_valid = 1'b1;
            end else i_valid = 1'b0;
            tick;
            chk("t4_stall_valid", 64'(o_valid), 64'd1);
            chk("t4_stall_ready", 64'(o_ready), 64'd0);
            check_result("t4_stall", 32'h7FFF_FFFE, 1'b0, 1'b0);
        end
        i_valid = 1'b0;
        consume("t4");
        tick; tick;
        chk("t4_ignored_req", 64'(o_busy), 64'd0);

        i_a = 32'hFFFF_FFFF; i_b = 32'h0; i_bin = 1'b0; i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        tick; tick;
        i_rst = 1'b1;
        tick;
        i_rst = 1'b0;
        chk("t5_ready", 64'(o_ready), 64'd1);
        chk("t5_valid", 64'(o_valid), 64'd0);
        chk("t5_busy", 64'(o_busy), 64'd0);
        chk("t5_diff", 64'(o_diff), 64'd0);
        chk("t5_borrow", 64'(o_borrow), 64'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick;
                if (o_valid) seen++;
            end
            chk("t5_no_valid", 64'(seen), 64'd0);
        end

        for (int i = 0; i < 100; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
            sc[i] = 1'($urandom_range(1));
        end
        sa[0] = 32'h0; sb[0] = 32'hFFFF_FFFF; sc[0] = 1'b1;
        begin
            int send = 0, recv = 0, cyc = 0, last_t = 0;
            logic acc;
            i_ready = 1'b1; i_valid = 1'b1;
            i_a = sa[0]; i_b = sb[0]; i_bin = sc[0];
            while (recv < 100 && cyc < 2000) begin
                acc = o_ready && i_valid;
                tick;
                cyc++;
                if (acc) begin
                    send++;
                    if (send < 100) begin
                        i_a = sa[send]; i_b = sb[send]; i_bin = sc[send];
                    end else i_valid = 1'b0;
                end
                if (o_valid) begin
                    r = {1'b0, sa[recv]} - {1'b0, sb[recv]} - 33'(sc[recv]);
                    chk("t6_diff", 64'(o_diff), 64'(r[31:0]));
                    chk("t6_borrow", 64'(o_borrow), 64'(r[32]));
                    chk("t6_zero", 64'(o_zero), 64'(r[31:0] == 32'h0));
                    if (recv > 0) chk("t6_interval", 64'(cyc - last_t), 64'd10);
                    last_t = cyc;
                    recv++;
                end
            end
            chk("t6_count", 64'(recv), 64'd100);
            i_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
